logic_reduce_n: RTL and testbench



---
 rtl/logic_reduce_n_if.sv | 39 +++
 rtl/logic_reduce_n.sv | 121 ++++++++++++
 tb/tb_logic_reduce_n.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_reduce_n_if.sv
// logic_reduce_n_if: operand/result handshake bundle for logic_reduce_n.
// The master side is the operand source plus result consumer; the slave
// side is the reduction block. The out_parity signal only exists when
// LOGIC_REDUCE_PARITY_EN is defined.
interface logic_reduce_n_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_inv;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_beats;
`ifdef LOGIC_REDUCE_PARITY_EN
  logic             out_parity;
`endif

  modport master (
    output in_valid, in_a, in_b, in_op, in_inv, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats
`ifdef LOGIC_REDUCE_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_inv, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beats
`ifdef LOGIC_REDUCE_PARITY_EN
    , output out_parity
`endif
  );
endinterface

// File: rtl/logic_reduce_n.sv
// logic_reduce_n: streaming bitwise AND/OR/XOR reducer.
// Each accepted beat computes a OP b, and the beat results are folded with
// the same OP across a packet delimited by in_last. The op and the output
// inversion are taken from the first beat of a packet. The result is held
// until the consumer accepts it. Optional out_parity port is enabled by
// defining LOGIC_REDUCE_PARITY_EN.
module logic_reduce_n #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  logic_reduce_n_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] BEATS_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [1:0]       op_q;
  logic             inv_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] beats;
  logic [WIDTH-1:0] data_q;
`ifdef LOGIC_REDUCE_PARITY_EN
  logic             parity_q;
`endif

  logic             accept;
  logic             first_beat;
  logic [1:0]       op_eff;
  logic             inv_eff;
  logic [WIDTH-1:0] beat_res;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] result;

  // Op code 11 is deliberately folded onto AND.
  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (op)
      2'b01:   apply_op = x | y;
      2'b10:   apply_op = x ^ y;
      default: apply_op = x & y;
    endcase
  endfunction

  // Any beat accepted outside ACCUM opens a new packet, including one that
  // arrives in HOLD in the same cycle the old result is consumed.
  assign accept     = bus.in_valid & bus.in_ready;
  assign first_beat = (state != ACCUM);
  assign op_eff     = first_beat ? bus.in_op  : op_q;
  assign inv_eff    = first_beat ? bus.in_inv : inv_q;
  assign beat_res   = apply_op(op_eff, bus.in_a, bus.in_b);
  assign acc_next   = first_beat ? beat_res : apply_op(op_eff, acc, beat_res);
  assign result     = inv_eff ? ~acc_next : acc_next;

  assign bus.in_ready  = (state != HOLD) | bus.out_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_beats = beats;
`ifdef LOGIC_REDUCE_PARITY_EN
  assign bus.out_parity = parity_q;
`endif

  // State register; reset drops any partially accumulated packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: packets open on accepted beats, HOLD waits for out_ready.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) state_next = bus.in_last ? HOLD : ACCUM;
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (accept) state_next = bus.in_last ? HOLD : ACCUM;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: fold accepted beats, count them with saturation, and
  // register the (optionally inverted) result on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 2'b00;
      inv_q    <= 1'b0;
      acc      <= '0;
      beats    <= '0;
      data_q   <= '0;
`ifdef LOGIC_REDUCE_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (accept) begin
      acc <= acc_next;
      if (first_beat) begin
        op_q  <= bus.in_op;
        inv_q <= bus.in_inv;
        beats <= CNT_W'(1);
      end else if (beats != BEATS_MAX) begin
        beats <= beats + CNT_W'(1);
      end
      if (bus.in_last) begin
        data_q   <= result;
`ifdef LOGIC_REDUCE_PARITY_EN
        parity_q <= ^result;
`endif
      end
    end
  end

endmodule

// File: tb/tb_logic_reduce_n.sv
// tb_logic_reduce_n: directed self-checking bench for logic_reduce_n.
// A 16-bit/8-bit-counter instance covers the main behaviour; a second
// instance with a 2-bit counter covers beat-count saturation.
module tb_logic_reduce_n;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic_reduce_n_if #(.WIDTH(16), .CNT_W(8)) bus ();
  logic_reduce_n_if #(.WIDTH(16), .CNT_W(2)) sat_bus ();

  logic_reduce_n #(.WIDTH(16), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic_reduce_n #(.WIDTH(16), .CNT_W(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sat_bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one beat on the main bus, waits (bounded) for in_ready, and
  // returns #1 after the accepting edge.
  task automatic drive_beat(input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] op, input logic inv,
                            input logic last);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_inv   = inv;
    bus.in_last  = last;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) begin
      tests++; fails++;
      $display("[TB] FAIL ready_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    tests++;
    if (bus.out_data !== 16'h0000 || bus.out_beats !== 8'd0) begin
      fails++; $display("[TB] FAIL reset_outputs: data=%h beats=%0d want 0/0",
                        bus.out_data, bus.out_beats);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_packet();
    drive_beat(16'hFFFF, 16'hFFFF, 2'b00, 1'b0, 1'b0);
    drive_beat(16'hFFFF, 16'hFFFF, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_beats !== 8'd0 || bus.in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL mid_reset: valid=%b beats=%0d ready=%b want 0/0/1",
                        bus.out_valid, bus.out_beats, bus.in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_beat(16'hFFFF, 16'h00FF, 2'b00, 1'b0, 1'b1);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h00FF || bus.out_beats !== 8'd1) begin
      fails++; $display("[TB] FAIL after_reset_pkt: valid=%b data=%h beats=%0d want 1/00ff/1",
                        bus.out_valid, bus.out_data, bus.out_beats);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_and_packet();
    drive_beat(16'hFFFF, 16'hFF0F, 2'b00, 1'b0, 1'b0);
    drive_beat(16'hF0FF, 16'hFFFF, 2'b11, 1'b1, 1'b0);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL and_early_valid: got %b want 0", bus.out_valid);
    end
    drive_beat(16'hFFFF, 16'h0FFF, 2'b01, 1'b1, 1'b1);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h000F || bus.out_beats !== 8'd3) begin
      fails++; $display("[TB] FAIL and3: valid=%b data=%h beats=%0d want 1/000f/3",
                        bus.out_valid, bus.out_data, bus.out_beats);
    end
    @(posedge clk); #1;
    drive_beat(16'hFFFF, 16'hFF0F, 2'b00, 1'b1, 1'b0);
    drive_beat(16'hF0FF, 16'hFFFF, 2'b00, 1'b0, 1'b0);
    drive_beat(16'hFFFF, 16'h0FFF, 2'b00, 1'b0, 1'b1);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hFFF0) begin
      fails++; $display("[TB] FAIL nand3: valid=%b data=%h want 1/fff0",
                        bus.out_valid, bus.out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_xor_fold();
    drive_beat(16'h1234, 16'h0000, 2'b10, 1'b0, 1'b0);
    drive_beat(16'h00FF, 16'h0F0F, 2'b00, 1'b0, 1'b1);
    tests++;
    if (bus.out_data !== 16'h1DC4 || bus.out_beats !== 8'd2) begin
      fails++; $display("[TB] FAIL xor2: data=%h beats=%0d want 1dc4/2",
                        bus.out_data, bus.out_beats);
    end
`ifdef LOGIC_REDUCE_PARITY_EN
    tests++;
    if (bus.out_parity !== 1'b1) begin
      fails++; $display("[TB] FAIL xor2_parity: got %b want 1", bus.out_parity);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive_beat(16'hAAAA, 16'hFFFF, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== 16'hAAAA) begin
        fails++; $display("[TB] FAIL hold_cycle%0d: valid=%b ready=%b data=%h want 1/0/aaaa",
                          i, bus.out_valid, bus.in_ready, bus.out_data);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0001;
    bus.in_b     = 16'h8000;
    bus.in_op    = 2'b01;
    bus.in_inv   = 1'b0;
    bus.in_last  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_data !== 16'hAAAA) begin
      fails++; $display("[TB] FAIL release: ready=%b data=%h want 1/aaaa",
                        bus.in_ready, bus.out_data);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h8001 || bus.out_beats !== 8'd1) begin
      fails++; $display("[TB] FAIL release_next: valid=%b data=%h beats=%0d want 1/8001/1",
                        bus.out_valid, bus.out_data, bus.out_beats);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_op_latch();
    drive_beat(16'h0001, 16'h0002, 2'b01, 1'b0, 1'b0);
    drive_beat(16'h0004, 16'h0000, 2'b00, 1'b1, 1'b1);
    tests++;
    if (bus.out_data !== 16'h0007) begin
      fails++; $display("[TB] FAIL op_latch: data=%h want 0007", bus.out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [1:0]  vop [3];
    logic        vinv [3];
    logic [15:0] vexp [3];
    va[0] = 16'hF0F0; vb[0] = 16'hFF00; vop[0] = 2'b00; vinv[0] = 1'b0; vexp[0] = 16'hF000;
    va[1] = 16'hFFFF; vb[1] = 16'h0F0F; vop[1] = 2'b10; vinv[1] = 1'b1; vexp[1] = 16'h0F0F;
    va[2] = 16'h0001; vb[2] = 16'h0010; vop[2] = 2'b01; vinv[2] = 1'b0; vexp[2] = 16'h0011;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = va[i];
      bus.in_b     = vb[i];
      bus.in_op    = vop[i];
      bus.in_inv   = vinv[i];
      bus.in_last  = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== vexp[i] || bus.out_beats !== 8'd1) begin
        fails++; $display("[TB] FAIL b2b%0d: valid=%b data=%h beats=%0d want 1/%h/1",
                          i, bus.out_valid, bus.out_data, bus.out_beats, vexp[i]);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_drain: valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_saturation();
    sat_bus.out_ready = 1'b1;
    sat_bus.in_op     = 2'b01;
    sat_bus.in_inv    = 1'b0;
    sat_bus.in_b      = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      sat_bus.in_valid = 1'b1;
      sat_bus.in_a     = 16'(1 << i);
      sat_bus.in_last  = (i == 4);
      @(posedge clk); #1;
    end
    sat_bus.in_valid = 1'b0;
    sat_bus.in_last  = 1'b0;
    tests++;
    if (sat_bus.out_valid !== 1'b1 || sat_bus.out_beats !== 2'd3 || sat_bus.out_data !== 16'h001F) begin
      fails++; $display("[TB] FAIL saturate: valid=%b beats=%0d data=%h want 1/3/001f",
                        sat_bus.out_valid, sat_bus.out_beats, sat_bus.out_data);
    end
    @(posedge clk); #1;
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    tests = 0;
    fails = 0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = 2'b00;
    bus.in_inv = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    sat_bus.in_valid = 1'b0; sat_bus.in_a = '0; sat_bus.in_b = '0; sat_bus.in_op = 2'b00;
    sat_bus.in_inv = 1'b0; sat_bus.in_last = 1'b0; sat_bus.out_ready = 1'b1;
    test_reset();
    test_reset_mid_packet();
    test_and_packet();
    test_xor_fold();
    test_backpressure();
    test_op_latch();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
